// File: rtl/mem_writeback_pkg.sv
// Shared definitions for the memory-access / writeback stage and decode.
//  - funct3 access size codes
//  - FSM state encoding
//  - opcode constants (decode uses these too)
//  - store formatting and alignment helpers
package mem_writeback_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    // Size is carried in funct3[1:0]; unknown sizes are treated as word.
    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] store_wstrb(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_writeback_if.sv
// Data-memory valid/ready port.
//  master (mem_writeback): drives request fields, receives ready and load data.
//  slave  (memory):        drives ready, rsp_valid and rdata.
interface mem_writeback_if;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );
endinterface

// File: rtl/mem_writeback_load_align.sv
// load_align: combinational load formatting.
//  rdata  in  32  full memory word
//  lane   in  2   byte offset of the access
//  funct3 in  3   access size / signedness
//  data   out 32  lane-selected, sign/zero-extended value
module load_align
    import mem_writeback_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [3:0][7:0] bytes;
    logic [7:0]      b;
    logic [15:0]     h;

    assign bytes = rdata;
    assign b     = bytes[lane];
    // Halfwords are 2-byte aligned by the time they get here, so lane[1] picks the half.
    assign h     = lane[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (funct3)
            F3_B:    data = {{24{b[7]}}, b};
            F3_BU:   data = {24'd0, b};
            F3_H:    data = {{16{h[15]}}, h};
            F3_HU:   data = {16'd0, h};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_writeback.sv
// mem_writeback: memory-access + writeback stage.
//  clk, reset          clock, async active-high reset
//  ex_*                executed op from execute (accepted on ex_valid && !stall_out)
//  stall_out           high while a memory access is in flight
//  dmem                data-memory valid/ready port (master)
//  wb_data/wb_rd       writeback value/register, held between pulses
//  wb_reg_write        one-cycle register write pulse (never for x0)
//  misaligned, bus_err one-cycle error pulses
module mem_writeback
    import mem_writeback_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rs2_data,
    input  logic [4:0]  ex_rd,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    output logic        stall_out,
    mem_writeback_if.master dmem,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        misaligned,
    output logic        bus_err
);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t          state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]      f3_q;
    logic [1:0]      lane_q;
    logic [4:0]      rd_q;
    logic            rw_q;
    logic            we_q;
    logic [31:0]     addr_q, wdata_q;
    logic [3:0]      wstrb_q;
    logic [31:0]     ld_data;
    logic            accept, is_mem, mis, waiting, timeout;

    assign accept  = ex_valid && (state == ST_IDLE);
    assign is_mem  = ex_mem_read || ex_mem_write;
    assign mis     = addr_misaligned(ex_funct3, ex_alu_result[1:0]);
    assign waiting = ((state == ST_REQ) && !dmem.dmem_req_ready) ||
                     ((state == ST_RSP) && !dmem.dmem_rsp_valid);
    // Fires on the TIMEOUT_CYCLES-th consecutive waiting cycle in REQ or RSP.
    assign timeout = (TIMEOUT_CYCLES != 0) && waiting && (cnt == CNT_LAST);

    assign stall_out           = (state != ST_IDLE);
    assign dmem.dmem_req_valid = (state == ST_REQ);
    assign dmem.dmem_we        = we_q;
    assign dmem.dmem_addr      = addr_q;
    assign dmem.dmem_wdata     = wdata_q;
    assign dmem.dmem_wstrb     = wstrb_q;

    load_align u_load_align (
        .rdata  (dmem.dmem_rdata),
        .lane   (lane_q),
        .funct3 (f3_q),
        .data   (ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && is_mem && !mis) state_nxt = ST_REQ;
            ST_REQ: begin
                if (timeout)                   state_nxt = ST_IDLE;
                else if (dmem.dmem_req_ready)  state_nxt = we_q ? ST_IDLE : ST_RSP;
            end
            ST_RSP: begin
                // A response is only looked at here, never in the handshake cycle.
                if (timeout || dmem.dmem_rsp_valid) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Cleared on every state change so each REQ/RSP visit starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   cnt <= '0;
        else if (state_nxt != state) cnt <= '0;
        else if (waiting)            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            misaligned   <= 1'b0;
            bus_err      <= 1'b0;
            f3_q         <= '0;
            lane_q       <= '0;
            rd_q         <= '0;
            rw_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
        end else begin
            wb_reg_write <= 1'b0;
            misaligned   <= 1'b0;
            bus_err      <= timeout;
            if (accept) begin
                if (!is_mem) begin
                    wb_data      <= ex_alu_result;
                    wb_rd        <= ex_rd;
                    wb_reg_write <= ex_reg_write && (ex_rd != 5'd0);
                end else if (mis) begin
                    misaligned <= 1'b1;
                end else begin
                    // Request fields stay frozen until the next accepted access.
                    f3_q    <= ex_funct3;
                    lane_q  <= ex_alu_result[1:0];
                    rd_q    <= ex_rd;
                    rw_q    <= ex_reg_write;
                    we_q    <= ex_mem_write;
                    addr_q  <= {ex_alu_result[31:2], 2'b00};
                    wdata_q <= store_wdata(ex_funct3, ex_rs2_data);
                    wstrb_q <= ex_mem_write ? store_wstrb(ex_funct3, ex_alu_result[1:0]) : 4'b0000;
                end
            end
            if ((state == ST_RSP) && dmem.dmem_rsp_valid) begin
                wb_data      <= ld_data;
                wb_rd        <= rd_q;
                wb_reg_write <= rw_q && (rd_q != 5'd0);
            end
        end
    end
endmodule

// File: tb/tb_mem_writeback.sv
module tb_mem_writeback;
    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        stall_out;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        misaligned;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_writeback_if dmem_if ();

    mem_writeback #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_alu_result (ex_alu_result),
        .ex_rs2_data   (ex_rs2_data),
        .ex_rd         (ex_rd),
        .ex_funct3     (ex_funct3),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .stall_out     (stall_out),
        .dmem          (dmem_if),
        .wb_data       (wb_data),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .misaligned    (misaligned),
        .bus_err       (bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                         input logic [2:0] f3, input logic rw, input logic mr, input logic mw);
        ex_valid      = 1'b1;
        ex_alu_result = a;
        ex_rs2_data   = d;
        ex_rd         = rd;
        ex_funct3     = f3;
        ex_reg_write  = rw;
        ex_mem_read   = mr;
        ex_mem_write  = mw;
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_stall"}, {31'd0, stall_out}, 32'd0);
        chk({pfx, "_req_valid"}, {31'd0, dmem_if.dmem_req_valid}, 32'd0);
        chk({pfx, "_we"}, {31'd0, dmem_if.dmem_we}, 32'd0);
        chk({pfx, "_addr"}, dmem_if.dmem_addr, 32'd0);
        chk({pfx, "_wdata"}, dmem_if.dmem_wdata, 32'd0);
        chk({pfx, "_wstrb"}, {28'd0, dmem_if.dmem_wstrb}, 32'd0);
        chk({pfx, "_wb_data"}, wb_data, 32'd0);
        chk({pfx, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
        chk({pfx, "_wb_we"}, {31'd0, wb_reg_write}, 32'd0);
        chk({pfx, "_misaligned"}, {31'd0, misaligned}, 32'd0);
        chk({pfx, "_bus_err"}, {31'd0, bus_err}, 32'd0);
    endtask

    initial begin
        int  n;
        logic wb_seen;
        reset = 1'b1;
        ex_valid = 1'b0; ex_alu_result = '0; ex_rs2_data = '0; ex_rd = '0;
        ex_funct3 = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        dmem_if.dmem_req_ready = 1'b0;
        dmem_if.dmem_rsp_valid = 1'b0;
        dmem_if.dmem_rdata     = '0;
        step; step;
        check_all_zero("rst");
        reset = 1'b0;
        step;

        // ADDI -> wb next cycle, no stall
        issue(32'h0000_0042, 32'h0, 5'd5, 3'b000, 1'b1, 1'b0, 1'b0);
        chk("alu_stall_pre", {31'd0, stall_out}, 32'd0);
        step;
        ex_valid = 1'b0;
        chk("alu_wb_we", {31'd0, wb_reg_write}, 32'd1);
        chk("alu_wb_rd", {27'd0, wb_rd}, 32'd5);
        chk("alu_wb_data", wb_data, 32'h42);
        chk("alu_stall", {31'd0, stall_out}, 32'd0);
        step;
        chk("alu_pulse_end", {31'd0, wb_reg_write}, 32'd0);
        chk("alu_data_held", wb_data, 32'h42);

        // ALU to x0: data/rd driven, no write pulse
        issue(32'h0000_0007, 32'h0, 5'd0, 3'b000, 1'b1, 1'b0, 1'b0);
        step;
        ex_valid = 1'b0;
        chk("x0_wb_we", {31'd0, wb_reg_write}, 32'd0);
        chk("x0_wb_data", wb_data, 32'h7);
        chk("x0_wb_rd", {27'd0, wb_rd}, 32'd0);

        // LB 0x1003, ready after 2 cycles, rsp one cycle after handshake
        issue(32'h0000_1003, 32'h0, 5'd7, 3'b000, 1'b1, 1'b1, 1'b0);
        step;
        ex_valid = 1'b0;
        chk("lb_req_valid", {31'd0, dmem_if.dmem_req_valid}, 32'd1);
        chk("lb_addr", dmem_if.dmem_addr, 32'h0000_1000);
        chk("lb_we", {31'd0, dmem_if.dmem_we}, 32'd0);
        chk("lb_stall0", {31'd0, stall_out}, 32'd1);
        step;
        chk("lb_req_hold", {31'd0, dmem_if.dmem_req_valid}, 32'd1);
        chk("lb_stall1", {31'd0, stall_out}, 32'd1);
        dmem_if.dmem_req_ready = 1'b1;
        step;
        dmem_if.dmem_req_ready = 1'b0;
        chk("lb_rsp_req_low", {31'd0, dmem_if.dmem_req_valid}, 32'd0);
        chk("lb_stall2", {31'd0, stall_out}, 32'd1);
        chk("lb_no_early_wb", {31'd0, wb_reg_write}, 32'd0);
        dmem_if.dmem_rsp_valid = 1'b1;
        dmem_if.dmem_rdata     = 32'h80FF_FFFF;
        step;
        dmem_if.dmem_rsp_valid = 1'b0;
        chk("lb_wb_we", {31'd0, wb_reg_write}, 32'd1);
        chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
        chk("lb_wb_rd", {27'd0, wb_rd}, 32'd7);
        chk("lb_stall_done", {31'd0, stall_out}, 32'd0);
        step;
        chk("lb_pulse_end", {31'd0, wb_reg_write}, 32'd0);

        // LHU 0x1002, ready immediately
        issue(32'h0000_1002, 32'h0, 5'd8, 3'b101, 1'b1, 1'b1, 1'b0);
        dmem_if.dmem_req_ready = 1'b1;
        step;
        ex_valid = 1'b0;
        chk("lhu_addr", dmem_if.dmem_addr, 32'h0000_1000);
        step;
        dmem_if.dmem_req_ready = 1'b0;
        dmem_if.dmem_rsp_valid = 1'b1;
        dmem_if.dmem_rdata     = 32'hBEEF_1234;
        step;
        dmem_if.dmem_rsp_valid = 1'b0;
        chk("lhu_wb_data", wb_data, 32'h0000_BEEF);
        chk("lhu_wb_we", {31'd0, wb_reg_write}, 32'd1);

        // SH 0x2002, ready low 5 cycles with stable request fields
        issue(32'h0000_2002, 32'h0000_ABCD, 5'd9, 3'b001, 1'b0, 1'b0, 1'b1);
        step;
        ex_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("sh_req_valid", {31'd0, dmem_if.dmem_req_valid}, 32'd1);
            chk("sh_we", {31'd0, dmem_if.dmem_we}, 32'd1);
            chk("sh_addr", dmem_if.dmem_addr, 32'h0000_2000);
            chk("sh_wdata", dmem_if.dmem_wdata, 32'hABCD_ABCD);
            chk("sh_wstrb", {28'd0, dmem_if.dmem_wstrb}, 32'hC);
            step;
        end
        dmem_if.dmem_req_ready = 1'b1;
        step;
        dmem_if.dmem_req_ready = 1'b0;
        chk("sh_idle", {31'd0, stall_out}, 32'd0);
        chk("sh_req_drop", {31'd0, dmem_if.dmem_req_valid}, 32'd0);
        chk("sh_no_wb", {31'd0, wb_reg_write}, 32'd0);

        // SB 0x2001 byte lane 1
        issue(32'h0000_2001, 32'h1234_5678, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1);
        dmem_if.dmem_req_ready = 1'b1;
        step;
        ex_valid = 1'b0;
        chk("sb_wdata", dmem_if.dmem_wdata, 32'h7878_7878);
        chk("sb_wstrb", {28'd0, dmem_if.dmem_wstrb}, 32'h2);
        step;
        dmem_if.dmem_req_ready = 1'b0;
        chk("sb_done", {31'd0, stall_out}, 32'd0);

        // LW 0x3001 misaligned
        issue(32'h0000_3001, 32'h0, 5'd9, 3'b010, 1'b1, 1'b1, 1'b0);
        step;
        ex_valid = 1'b0;
        chk("mis_pulse", {31'd0, misaligned}, 32'd1);
        chk("mis_no_req", {31'd0, dmem_if.dmem_req_valid}, 32'd0);
        chk("mis_no_stall", {31'd0, stall_out}, 32'd0);
        chk("mis_no_wb", {31'd0, wb_reg_write}, 32'd0);
        step;
        chk("mis_pulse_end", {31'd0, misaligned}, 32'd0);
        chk("mis_no_req2", {31'd0, dmem_if.dmem_req_valid}, 32'd0);

        // Load whose response never comes -> bus_err after 8 waiting cycles
        issue(32'h0000_5000, 32'h0, 5'd11, 3'b010, 1'b1, 1'b1, 1'b0);
        dmem_if.dmem_req_ready = 1'b1;
        step;
        ex_valid = 1'b0;
        step;
        dmem_if.dmem_req_ready = 1'b0;
        n = 0;
        wb_seen = 1'b0;
        while (!bus_err && n < 20) begin
            step;
            n++;
            if (wb_reg_write) wb_seen = 1'b1;
        end
        chk("to_cycles", n, 32'd8);
        chk("to_bus_err", {31'd0, bus_err}, 32'd1);
        chk("to_idle", {31'd0, stall_out}, 32'd0);
        chk("to_req_low", {31'd0, dmem_if.dmem_req_valid}, 32'd0);
        chk("to_no_wb", {31'd0, wb_seen}, 32'd0);
        step;
        chk("to_pulse_end", {31'd0, bus_err}, 32'd0);

        // Async reset while in RSP
        issue(32'h0000_4000, 32'h0, 5'd10, 3'b010, 1'b1, 1'b1, 1'b0);
        dmem_if.dmem_req_ready = 1'b1;
        step;
        ex_valid = 1'b0;
        step;
        dmem_if.dmem_req_ready = 1'b0;
        chk("rr_in_rsp", {31'd0, stall_out}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("rr");
        @(posedge clk);
        #1;
        reset = 1'b0;
        dmem_if.dmem_rsp_valid = 1'b1;
        dmem_if.dmem_rdata     = 32'h1111_2222;
        step;
        dmem_if.dmem_rsp_valid = 1'b0;
        chk("rr_no_wb", {31'd0, wb_reg_write}, 32'd0);
        chk("rr_idle", {31'd0, stall_out}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
